// File: rtl/router_psum_pkg.sv
// rtl/router_psum_pkg.sv - port indices, mode constants and routing table for the psum router
//
// Purpose : shared constants and the mode -> (destination, source) routing table.
// Contents: PORT_GLB/PORT_PE/PORT_NB, MODE_0..MODE_7, route_t, route_table().
package psum_router_pkg;

   localparam int NUM_PORTS = 3;

   localparam int PORT_GLB = 0;
   localparam int PORT_PE  = 1;
   localparam int PORT_NB  = 2;

   localparam logic [2:0] MODE_0 = 3'd0;
   localparam logic [2:0] MODE_1 = 3'd1;
   localparam logic [2:0] MODE_2 = 3'd2;
   localparam logic [2:0] MODE_3 = 3'd3;
   localparam logic [2:0] MODE_4 = 3'd4;
   localparam logic [2:0] MODE_5 = 3'd5;
   localparam logic [2:0] MODE_6 = 3'd6;
   localparam logic [2:0] MODE_7 = 3'd7;

   // One entry per destination: which source feeds it, and whether it is fed at all.
   typedef struct packed {
      logic       routed;
      logic [1:0] src;
   } route_t;

   typedef route_t [NUM_PORTS-1:0] route_vec_t;

   function automatic route_t hop(input int src);
      return route_t'{routed: 1'b1, src: 2'(src)};
   endfunction

   // Every mapping is one-to-one, so a source appears at most once per mode.
   function automatic route_vec_t route_table(input logic [2:0] mode);
      route_vec_t r;
      r = '0;
      case (mode)
         MODE_0: begin r[PORT_GLB] = hop(PORT_GLB); r[PORT_PE] = hop(PORT_NB); end
         MODE_1: begin r[PORT_GLB] = hop(PORT_PE); end
         MODE_2: begin r[PORT_GLB] = hop(PORT_NB); r[PORT_NB] = hop(PORT_PE); end
         MODE_3: begin r[PORT_PE]  = hop(PORT_GLB); r[PORT_NB] = hop(PORT_PE); end
         MODE_4: begin r[PORT_PE]  = hop(PORT_NB); r[PORT_GLB] = hop(PORT_PE); end
         MODE_5: begin r[PORT_GLB] = hop(PORT_GLB); r[PORT_NB] = hop(PORT_PE); end
         MODE_6: begin r[PORT_GLB] = hop(PORT_GLB); r[PORT_NB] = hop(PORT_NB); end
         MODE_7: begin
            r[PORT_GLB] = hop(PORT_GLB);
            r[PORT_PE]  = hop(PORT_NB);
            r[PORT_NB]  = hop(PORT_PE);
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/router_psum_if.sv
// rtl/router_psum_if.sv - three bidirectional ready/enable psum port pairs
//
// Purpose : bundles the src/dst handshakes of ports 0 (GLB), 1 (PE), 2 (neighbour row).
// Modports: slave  - the router (drives ready_src_*, data_dst_*, enable_dst_*)
//           master - the surrounding logic (drives data_src_*, enable_src_*, ready_dst_*)
interface router_psum_if #(
   parameter int DATA_WIDTH = 20
);
   logic                  ready_src_port_0, ready_src_port_1, ready_src_port_2;
   logic [DATA_WIDTH-1:0] data_src_port_0, data_src_port_1, data_src_port_2;
   logic                  enable_src_port_0, enable_src_port_1, enable_src_port_2;
   logic                  ready_dst_port_0, ready_dst_port_1, ready_dst_port_2;
   logic [DATA_WIDTH-1:0] data_dst_port_0, data_dst_port_1, data_dst_port_2;
   logic                  enable_dst_port_0, enable_dst_port_1, enable_dst_port_2;

   modport slave (
      output ready_src_port_0, ready_src_port_1, ready_src_port_2,
      input  data_src_port_0, data_src_port_1, data_src_port_2,
      input  enable_src_port_0, enable_src_port_1, enable_src_port_2,
      input  ready_dst_port_0, ready_dst_port_1, ready_dst_port_2,
      output data_dst_port_0, data_dst_port_1, data_dst_port_2,
      output enable_dst_port_0, enable_dst_port_1, enable_dst_port_2
   );

   modport master (
      input  ready_src_port_0, ready_src_port_1, ready_src_port_2,
      output data_src_port_0, data_src_port_1, data_src_port_2,
      output enable_src_port_0, enable_src_port_1, enable_src_port_2,
      output ready_dst_port_0, ready_dst_port_1, ready_dst_port_2,
      input  data_dst_port_0, data_dst_port_1, data_dst_port_2,
      input  enable_dst_port_0, enable_dst_port_1, enable_dst_port_2
   );
endinterface

// File: rtl/router_psum_route_dec.sv
// rtl/router_psum_route_dec.sv - decodes the registered mode into per-destination source selects
//
// Purpose : mode -> for each destination, a source index and a routed flag.
// Ports   : mode      in  3       registered routing mode
//           src_sel   out 3x2     source index feeding each destination
//           dst_valid out 3       destination is routed in this mode
module router_psum_route_dec
   import psum_router_pkg::*;
(
   input  logic [2:0]                mode,
   output logic [NUM_PORTS-1:0][1:0] src_sel,
   output logic [NUM_PORTS-1:0]      dst_valid
);

   route_vec_t tab;

   always_comb begin
      tab       = route_table(mode);
      src_sel   = '0;
      dst_valid = '0;
      for (int d = 0; d < NUM_PORTS; d++) begin
         src_sel[d]   = tab[d].src;
         dst_valid[d] = tab[d].routed;
      end
   end

endmodule

// File: rtl/router_psum.sv
// rtl/router_psum.sv - partial-sum router for one PE row, fixed mode-selected port mapping
//
// Purpose : registers the routing mode and steers data/enable forward and ready backward
//           combinationally between ports 0 (GLB), 1 (PE) and 2 (neighbour row).
// Ports   : clk_i          in  1   clock, rising edge
//           rst_ni         in  1   asynchronous active-low reset
//           router_mode_i  in  3   routing mode request, sampled every edge
//           bus            slave   the three src/dst handshake pairs
module router_psum
   import psum_router_pkg::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int FULL_PORTS = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [2:0]   router_mode_i,
   router_psum_if.slave bus
);

   if (FULL_PORTS != NUM_PORTS) begin : g_full_ports_check
      $error("router_psum: FULL_PORTS must be 3");
   end

   logic [2:0]                           mode_q;
   logic [NUM_PORTS-1:0][1:0]            src_sel;
   logic [NUM_PORTS-1:0]                 dst_valid;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_src, data_dst;
   logic [NUM_PORTS-1:0]                 enable_src, enable_dst;
   logic [NUM_PORTS-1:0]                 ready_src, ready_dst;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) mode_q <= MODE_0;
      else         mode_q <= router_mode_i;
   end

   router_psum_route_dec u_route_dec (
      .mode      (mode_q),
      .src_sel   (src_sel),
      .dst_valid (dst_valid)
   );

   assign data_src[0]   = bus.data_src_port_0;
   assign data_src[1]   = bus.data_src_port_1;
   assign data_src[2]   = bus.data_src_port_2;
   assign enable_src[0] = bus.enable_src_port_0;
   assign enable_src[1] = bus.enable_src_port_1;
   assign enable_src[2] = bus.enable_src_port_2;
   assign ready_dst[0]  = bus.ready_dst_port_0;
   assign ready_dst[1]  = bus.ready_dst_port_1;
   assign ready_dst[2]  = bus.ready_dst_port_2;

   // rst_ni gates the outputs directly: mode_q = 0 alone would still route mode 0
   // while reset is held, but every output must read 0 during reset.
   always_comb begin
      data_dst   = '0;
      enable_dst = '0;
      ready_src  = '0;
      if (rst_ni) begin
         for (int d = 0; d < NUM_PORTS; d++) begin
            if (dst_valid[d]) begin
               data_dst[d]   = data_src[src_sel[d]];
               enable_dst[d] = enable_src[src_sel[d]];
            end
         end
         // Ready travels back along the same pairing; one-to-one means at most one hit.
         for (int s = 0; s < NUM_PORTS; s++) begin
            for (int d = 0; d < NUM_PORTS; d++) begin
               if (dst_valid[d] && (src_sel[d] == 2'(s))) ready_src[s] = ready_dst[d];
            end
         end
      end
   end

   assign bus.data_dst_port_0   = data_dst[0];
   assign bus.data_dst_port_1   = data_dst[1];
   assign bus.data_dst_port_2   = data_dst[2];
   assign bus.enable_dst_port_0 = enable_dst[0];
   assign bus.enable_dst_port_1 = enable_dst[1];
   assign bus.enable_dst_port_2 = enable_dst[2];
   assign bus.ready_src_port_0  = ready_src[0];
   assign bus.ready_src_port_1  = ready_src[1];
   assign bus.ready_src_port_2  = ready_src[2];

endmodule

// File: tb/tb_router_psum.sv
// tb/tb_router_psum.sv - self-checking bench for router_psum
module tb_router_psum;

   logic clk = 1'b0;
   logic rst_n;
   logic [2:0] mode_in;
   always #5 clk = ~clk;

   router_psum_if #(.DATA_WIDTH(20)) bus ();
   router_psum u_dut (.clk_i(clk), .rst_ni(rst_n), .router_mode_i(mode_in), .bus(bus));

   logic [2:0][19:0] src_data;
   logic [2:0]       src_en, dst_rdy;
   logic [2:0][19:0] got_data;
   logic [2:0]       got_en, got_rs;

   assign bus.data_src_port_0 = src_data[0];
   assign bus.data_src_port_1 = src_data[1];
   assign bus.data_src_port_2 = src_data[2];
   assign bus.enable_src_port_0 = src_en[0];
   assign bus.enable_src_port_1 = src_en[1];
   assign bus.enable_src_port_2 = src_en[2];
   assign bus.ready_dst_port_0 = dst_rdy[0];
   assign bus.ready_dst_port_1 = dst_rdy[1];
   assign bus.ready_dst_port_2 = dst_rdy[2];
   assign got_data = {bus.data_dst_port_2, bus.data_dst_port_1, bus.data_dst_port_0};
   assign got_en   = {bus.enable_dst_port_2, bus.enable_dst_port_1, bus.enable_dst_port_0};
   assign got_rs   = {bus.ready_src_port_2, bus.ready_src_port_1, bus.ready_src_port_0};

   // Four-row vertical chain: row y dst2 -> row y+1 src2, ready flows back.
   logic [2:0] chain_mode [4];
   router_psum_if #(.DATA_WIDTH(20)) c0 ();
   router_psum_if #(.DATA_WIDTH(20)) c1 ();
   router_psum_if #(.DATA_WIDTH(20)) c2 ();
   router_psum_if #(.DATA_WIDTH(20)) c3 ();
   router_psum u_row0 (.clk_i(clk), .rst_ni(rst_n), .router_mode_i(chain_mode[0]), .bus(c0));
   router_psum u_row1 (.clk_i(clk), .rst_ni(rst_n), .router_mode_i(chain_mode[1]), .bus(c1));
   router_psum u_row2 (.clk_i(clk), .rst_ni(rst_n), .router_mode_i(chain_mode[2]), .bus(c2));
   router_psum u_row3 (.clk_i(clk), .rst_ni(rst_n), .router_mode_i(chain_mode[3]), .bus(c3));
   assign c1.data_src_port_2 = c0.data_dst_port_2;
   assign c1.enable_src_port_2 = c0.enable_dst_port_2;
   assign c0.ready_dst_port_2 = c1.ready_src_port_2;
   assign c2.data_src_port_2 = c1.data_dst_port_2;
   assign c2.enable_src_port_2 = c1.enable_dst_port_2;
   assign c1.ready_dst_port_2 = c2.ready_src_port_2;
   assign c3.data_src_port_2 = c2.data_dst_port_2;
   assign c3.enable_src_port_2 = c2.enable_dst_port_2;
   assign c2.ready_dst_port_2 = c3.ready_src_port_2;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: routing table [mode][dst] = source index, -1 when unrouted.
   int route_src [8][3];
   logic [2:0]       model_mode = 3'd0;
   logic [2:0][19:0] exp_data;
   logic [2:0]       exp_en, exp_rs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_mode <= 3'd0;
      else        model_mode <= mode_in;
   end

   task automatic predict(input bit in_rst);
      int s;
      exp_data = '0; exp_en = '0; exp_rs = '0;
      if (!in_rst) begin
         for (int d = 0; d < 3; d++) begin
            s = route_src[model_mode][d];
            if (s >= 0) begin
               exp_data[d] = src_data[s];
               exp_en[d]   = src_en[s];
               exp_rs[s]   = dst_rdy[d];
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      predict(!rst_n);
      for (int p = 0; p < 3; p++) begin
         check($sformatf("%s_data%0d_m%0d", tag, p, model_mode), 32'(got_data[p]), 32'(exp_data[p]));
         check($sformatf("%s_en%0d_m%0d", tag, p, model_mode), 32'(got_en[p]), 32'(exp_en[p]));
         check($sformatf("%s_rs%0d_m%0d", tag, p, model_mode), 32'(got_rs[p]), 32'(exp_rs[p]));
      end
   endtask

   typedef struct {
      logic [2:0]       mode;
      logic [2:0][19:0] d;
      logic [2:0]       en;
      logic [2:0]       rdy;
      logic [2:0][19:0] ed;
      logic [2:0]       een;
      logic [2:0]       ers;
   } vec_t;
   vec_t vecs [10];

   initial begin
      route_src = '{'{0, 2, -1}, '{1, -1, -1}, '{2, -1, 1}, '{-1, 0, 1},
                    '{1, 2, -1}, '{0, -1, 1}, '{0, -1, 2}, '{0, 2, 1}};
      // fields: mode, data{2,1,0}, en, rdy, exp data{2,1,0}, exp enable_dst, exp ready_src
      vecs[0] = '{3'd0, {20'd2, 20'd1, 20'd25}, 3'b111, 3'b111, {20'd0, 20'd2, 20'd25}, 3'b011, 3'b101};
      vecs[1] = '{3'd0, {20'd2, 20'd1, 20'd25}, 3'b111, 3'b110, {20'd0, 20'd2, 20'd25}, 3'b011, 3'b100};
      vecs[2] = '{3'd5, {20'd7, 20'd6, 20'd5},  3'b111, 3'b101, {20'd6, 20'd0, 20'd5},  3'b101, 3'b011};
      vecs[3] = '{3'd6, {20'd7, 20'd6, 20'd10}, 3'b111, 3'b110, {20'd7, 20'd0, 20'd10}, 3'b101, 3'b100};
      vecs[4] = '{3'd7, {20'd7, 20'd6, 20'd15}, 3'b111, 3'b111, {20'd6, 20'd7, 20'd15}, 3'b111, 3'b111};
      vecs[5] = '{3'd7, {20'd7, 20'd6, 20'd15}, 3'b111, 3'b110, {20'd6, 20'd7, 20'd15}, 3'b111, 3'b110};
      vecs[6] = '{3'd3, {20'h55555, 20'h00ABC, 20'h12345}, 3'b111, 3'b111,
                  {20'h00ABC, 20'h12345, 20'h0}, 3'b110, 3'b011};
      vecs[7] = '{3'd1, {20'd3, 20'h777, 20'd1}, 3'b010, 3'b111, {20'd0, 20'd0, 20'h777}, 3'b001, 3'b010};
      vecs[8] = '{3'd2, {20'hFFFFF, 20'd2, 20'd1}, 3'b100, 3'b101, {20'd2, 20'd0, 20'hFFFFF}, 3'b001, 3'b110};
      vecs[9] = '{3'd4, {20'd1, 20'hBEEF, 20'd9}, 3'b011, 3'b011, {20'd0, 20'd1, 20'hBEEF}, 3'b001, 3'b110};

      // Chain stimulus idle; rows 0..2 mode 2, row 3 mode 6.
      chain_mode = '{3'd2, 3'd2, 3'd2, 3'd6};
      c0.data_src_port_0 = '0; c0.enable_src_port_0 = 0; c0.data_src_port_1 = '0; c0.enable_src_port_1 = 0;
      c1.data_src_port_0 = '0; c1.enable_src_port_0 = 0; c1.data_src_port_1 = '0; c1.enable_src_port_1 = 0;
      c2.data_src_port_0 = '0; c2.enable_src_port_0 = 0; c2.data_src_port_1 = '0; c2.enable_src_port_1 = 0;
      c3.data_src_port_0 = '0; c3.enable_src_port_0 = 0; c3.data_src_port_1 = '0; c3.enable_src_port_1 = 0;
      c0.data_src_port_2 = '0; c0.enable_src_port_2 = 0; c3.ready_dst_port_2 = 1;
      c0.ready_dst_port_0 = 1; c0.ready_dst_port_1 = 1; c1.ready_dst_port_0 = 1; c1.ready_dst_port_1 = 1;
      c2.ready_dst_port_0 = 1; c2.ready_dst_port_1 = 1; c3.ready_dst_port_0 = 1; c3.ready_dst_port_1 = 1;

      // Reset: every output 0 regardless of inputs.
      rst_n = 1'b0; mode_in = 3'd0;
      src_data = {20'd7, 20'd7, 20'd7}; src_en = 3'b111; dst_rdy = 3'b111;
      #2;
      for (int p = 0; p < 3; p++) begin
         check($sformatf("rst_data%0d", p), 32'(got_data[p]), 32'd0);
         check($sformatf("rst_en%0d", p), 32'(got_en[p]), 32'd0);
         check($sformatf("rst_rs%0d", p), 32'(got_rs[p]), 32'd0);
      end
      @(posedge clk); #1;
      check("rst_held_en0", 32'(got_en[0]), 32'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      check("rel_data0", 32'(got_data[0]), 32'd7);
      check("rel_en0", 32'(got_en[0]), 32'd1);
      @(posedge clk); #1;
      check("rel_edge_data0", 32'(got_data[0]), 32'd7);
      check("rel_edge_en0", 32'(got_en[0]), 32'd1);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mode_in = vecs[i].mode; src_data = vecs[i].d; src_en = vecs[i].en; dst_rdy = vecs[i].rdy;
         @(posedge clk); #1;
         for (int p = 0; p < 3; p++)
            check($sformatf("vec%0d_data%0d", i, p), 32'(got_data[p]), 32'(vecs[i].ed[p]));
         check($sformatf("vec%0d_en", i), 32'(got_en), 32'(vecs[i].een));
         check($sformatf("vec%0d_rs", i), 32'(got_rs), 32'(vecs[i].ers));
      end

      // Same-cycle backpressure and mode switch timing.
      @(negedge clk);
      mode_in = 3'd0; src_data = {20'h222, 20'h111, 20'd25}; src_en = 3'b111; dst_rdy = 3'b111;
      @(posedge clk); #1;
      check("m0_rs0", 32'(got_rs[0]), 32'd1);
      dst_rdy[0] = 1'b0; #1;
      check("bp_same_cycle_rs0", 32'(got_rs[0]), 32'd0);
      dst_rdy[0] = 1'b1;
      @(negedge clk); mode_in = 3'd1; #1;
      check("switch_hold_data1", 32'(got_data[1]), 32'h222);
      check("switch_hold_rs0", 32'(got_rs[0]), 32'd1);
      @(posedge clk); #1;
      check("switch_data0", 32'(got_data[0]), 32'h111);
      check("switch_rs0", 32'(got_rs[0]), 32'd0);
      check("switch_en1", 32'(got_en[1]), 32'd0);

      // Randomized traffic against the reference model, with occasional async reset.
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         mode_in = 3'($urandom_range(0, 7));
         for (int p = 0; p < 3; p++) src_data[p] = 20'($urandom);
         src_en = 3'($urandom); dst_rdy = 3'($urandom);
         #1 check_model("rnd_pre");
         @(posedge clk); #1;
         check_model("rnd");
         if (i % 25 == 7) begin
            #2 rst_n = 1'b0; #1;
            check_model("rnd_rst");
            rst_n = 1'b1; #1;
            check_model("rnd_rel");
         end
      end

      // Four-row chain: psum injected at row 0 PE source reaches row 1 GLB destination.
      @(negedge clk);
      c0.data_src_port_1 = 20'hF00F; c0.enable_src_port_1 = 1'b1; #1;
      check("chain_row1_data0", 32'(c1.data_dst_port_0), 32'hF00F);
      check("chain_row1_en0", 32'(c1.enable_dst_port_0), 32'd1);
      check("chain_row2_en_src2", 32'(c2.enable_src_port_2), 32'd0);
      check("chain_row3_en_src2", 32'(c3.enable_src_port_2), 32'd0);
      check("chain_row0_rs1", 32'(c0.ready_src_port_1), 32'd1);
      c1.ready_dst_port_0 = 1'b0; #1;
      check("chain_row0_rs1_bp", 32'(c0.ready_src_port_1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
